// File: rtl/vga_fill_arbiter.sv
// rtl/vga_fill_arbiter.sv - VgaAdapter write-port arbiter: CPU priority plus rectangle-fill engine.
// Optional macro VGA_FILL_TRANSP_EN enables transparent-colour byte masking.
module vga_fill_arbiter #(
  parameter logic [31:0] FB_BASE      = 32'hFF000000,
  parameter logic [31:0] FB_END       = 32'hFF012BFF,
  parameter int          LINE_WORDS   = 80,
  parameter int          LINES        = 240
`ifdef VGA_FILL_TRANSP_EN
  ,
  parameter logic [7:0]  TRANSP_COLOR = 8'hC7
`endif
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iCpuWrite,
  input  logic [31:0] iCpuAddr,
  input  logic [31:0] iCpuWData,
  input  logic [3:0]  iCpuBE,
  input  logic        iFillStart,
  input  logic        iFillAbort,
  input  logic [6:0]  iFillX0,
  input  logic [7:0]  iFillY0,
  input  logic [6:0]  iFillW,
  input  logic [7:0]  iFillH,
  input  logic [7:0]  iFillColor,
  output logic [31:0] oVgaAddr,
  output logic [31:0] oVgaWData,
  output logic        oVgaWE,
  output logic [3:0]  oVgaBE,
  output logic        oFillBusy,
  output logic        oFillDone
);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

  localparam logic [7:0] LW8 = 8'(LINE_WORDS);
  localparam logic [8:0] LN9 = 9'(LINES);

  state_t     state, state_nxt;
  logic [6:0] x0_q, w_q, col_q;
  logic [7:0] y0_q, h_q, row_q, color_q;

  logic       cpu_hit;
  logic [3:0] cpu_be;
  logic       eng_go, eng_we, col_last, row_last;
  logic [7:0] w_avail, w_clip;
  logic [8:0] h_avail, h_clip;
  logic [31:0] eng_addr;

  assign cpu_hit = iCpuWrite && (iCpuAddr >= FB_BASE) && (iCpuAddr <= FB_END);

`ifdef VGA_FILL_TRANSP_EN
  always_comb begin
    for (int n = 0; n < 4; n++)
      cpu_be[n] = iCpuBE[n] && (iCpuWData[8*n +: 8] != TRANSP_COLOR);
  end
  assign eng_we = (color_q != TRANSP_COLOR);
`else
  assign cpu_be = iCpuBE;
  assign eng_we = 1'b1;
`endif

  // Clip against the screen edge at widened width so an out-of-range origin yields zero, not a wrap.
  assign w_avail = ({1'b0, iFillX0} >= LW8) ? 8'd0 : LW8 - {1'b0, iFillX0};
  assign h_avail = ({1'b0, iFillY0} >= LN9) ? 9'd0 : LN9 - {1'b0, iFillY0};
  assign w_clip  = ({1'b0, iFillW} < w_avail) ? {1'b0, iFillW} : w_avail;
  assign h_clip  = ({1'b0, iFillH} < h_avail) ? {1'b0, iFillH} : h_avail;

  assign col_last = ({1'b0, col_q} == ({1'b0, x0_q} + {1'b0, w_q} - 8'd1));
  assign row_last = ({1'b0, row_q} == ({1'b0, y0_q} + {1'b0, h_q} - 9'd1));
  assign eng_go   = (state == S_FILL) && !cpu_hit;
  assign eng_addr = FB_BASE + ((32'(row_q) * 32'(LINE_WORDS) + 32'(col_q)) << 2);

  always_comb begin
    oVgaAddr  = 32'd0;
    oVgaWData = 32'd0;
    oVgaWE    = 1'b0;
    oVgaBE    = 4'h0;
    if (cpu_hit) begin
      oVgaAddr  = iCpuAddr;
      oVgaWData = iCpuWData;
      oVgaWE    = 1'b1;
      oVgaBE    = cpu_be;
    end else if (state == S_FILL) begin
      oVgaAddr  = eng_addr;
      oVgaWData = {4{color_q}};
      oVgaWE    = eng_we;
      oVgaBE    = eng_we ? 4'hF : 4'h0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (iFillStart && !iFillAbort)
                state_nxt = (w_clip == 8'd0 || h_clip == 9'd0) ? S_DONE : S_FILL;
      S_FILL: if (iFillAbort)
                state_nxt = S_IDLE;
              else if (eng_go && col_last && row_last)
                state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign oFillBusy = (state == S_FILL);
  assign oFillDone = (state == S_DONE);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state   <= S_IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      color_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && iFillStart && !iFillAbort) begin
        x0_q    <= iFillX0;
        y0_q    <= iFillY0;
        w_q     <= w_clip[6:0];
        h_q     <= h_clip[7:0];
        col_q   <= iFillX0;
        row_q   <= iFillY0;
        color_q <= iFillColor;
      end else if (eng_go) begin
        // Raster order: wrap to the rectangle's left edge at the end of each row.
        if (col_last) begin
          col_q <= x0_q;
          row_q <= row_q + 8'd1;
        end else begin
          col_q <= col_q + 7'd1;
        end
      end
    end
  end

endmodule
